// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment frame decoder: segment patterns,
// FSM state type and the constant decimal weights.
package sevenseg_pkg;

    // Active-low segment patterns, bit6 = g .. bit0 = a
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    localparam int unsigned WEIGHT_0 = 1;
    localparam int unsigned WEIGHT_1 = 10;
    localparam int unsigned WEIGHT_2 = 100;
    localparam int unsigned WEIGHT_3 = 1000;

    typedef enum logic {
        ST_IDLE,
        ST_CAPTURE
    } state_e;

    function automatic int unsigned pow10(input logic [1:0] pos);
        case (pos)
            2'd0:    return WEIGHT_0;
            2'd1:    return WEIGHT_1;
            2'd2:    return WEIGHT_2;
            default: return WEIGHT_3;
        endcase
    endfunction

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Combinational lookup from an active-low segment pattern to a BCD digit
// plus a flag saying whether the pattern is one of the ten legal digits.
module sevenseg_pattern_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_frame_decoder.sv
// Reassembles a multiplexed seven-segment display scan into a binary number,
// one digit per strobe, starting at the units position.
module sevenseg_frame_decoder
    import sevenseg_pkg::*;
#(
    parameter int NDIG  = 2,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [6:0]       seg,
    input  logic [NDIG-1:0]  digit_en,
    input  logic             seg_strobe,
    output logic [WIDTH-1:0] number,
    output logic             number_valid,
    output logic             frame_error,
    output logic             busy
);

    localparam logic [1:0] LAST_POS = 2'(NDIG - 1);

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [1:0]       expPos_q;
    logic [WIDTH-1:0] number_q;
    logic             numberValid_q;
    logic             frameError_q;

    logic [3:0]       digit;
    logic             segValid;
    logic [NDIG-1:0]  activeLow;
    logic             anyLow;
    logic             singleLow;
    logic [1:0]       strobePos;
    logic [WIDTH-1:0] sum_d;

    sevenseg_pattern_decode u_decode (
        .seg   (seg),
        .digit (digit),
        .valid (segValid)
    );

    always_comb begin
        activeLow = ~digit_en;
        anyLow    = |activeLow;
        singleLow = $onehot(activeLow);
        strobePos = 2'd0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            if (activeLow[k]) strobePos = 2'(k);
        end
        sum_d = acc_q + WIDTH'(digit) * WIDTH'(pow10(strobePos));
    end

    // A strobe with no digit selected never reaches the FSM at all
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q       <= ST_IDLE;
            acc_q         <= '0;
            expPos_q      <= 2'd0;
            number_q      <= '0;
            numberValid_q <= 1'b0;
            frameError_q  <= 1'b0;
        end else begin
            numberValid_q <= 1'b0;
            frameError_q  <= 1'b0;
            if (seg_strobe && anyLow) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!singleLow || !segValid) begin
                            frameError_q <= 1'b1;
                        end else if (strobePos == 2'd0) begin
                            if (NDIG == 1) begin
                                number_q      <= WIDTH'(digit);
                                numberValid_q <= 1'b1;
                            end else begin
                                acc_q    <= WIDTH'(digit);
                                expPos_q <= 2'd1;
                                state_q  <= ST_CAPTURE;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        if (!singleLow || !segValid) begin
                            frameError_q <= 1'b1;
                            acc_q        <= '0;
                            expPos_q     <= 2'd0;
                            state_q      <= ST_IDLE;
                        end else if (strobePos == 2'd0) begin
                            // Scan resynchronised on the units digit: restart
                            frameError_q <= 1'b1;
                            acc_q        <= WIDTH'(digit);
                            expPos_q     <= 2'd1;
                        end else if (strobePos == expPos_q) begin
                            if (strobePos == LAST_POS) begin
                                number_q      <= sum_d;
                                numberValid_q <= 1'b1;
                                acc_q         <= '0;
                                expPos_q      <= 2'd0;
                                state_q       <= ST_IDLE;
                            end else begin
                                acc_q    <= sum_d;
                                expPos_q <= expPos_q + 2'd1;
                            end
                        end else begin
                            frameError_q <= 1'b1;
                            acc_q        <= '0;
                            expPos_q     <= 2'd0;
                            state_q      <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign number       = number_q;
    assign number_valid = numberValid_q;
    assign frame_error  = frameError_q;
    assign busy         = (state_q == ST_CAPTURE);

endmodule

// File: doc/sevenseg_frame_decoder.md
SEVENSEG_FRAME_DECODER -- requirements
Module: sevenseg_frame_decoder

Interface
REQ-001 Parameter NDIG, default 2, number of multiplexed decimal digits (1..4).
REQ-002 Parameter WIDTH, default 7, width of the reconstructed binary number; SHALL be >= ceil(log2(10^NDIG)).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 n_reset  input  1  synchronous, active-low reset.
REQ-005 seg  input  7  segment lines, active low, bit0=a .. bit6=g.
REQ-006 digit_en  input  NDIG  digit select, active low, bit k = decimal position k (0 = units).
REQ-007 seg_strobe  input  1  one-cycle sample request; seg/digit_en valid in the same cycle.
REQ-008 number  output  WIDTH  last complete reconstructed value.
REQ-009 number_valid  output  1  one-cycle pulse when number is updated.
REQ-010 frame_error  output  1  one-cycle pulse when a frame is aborted.
REQ-011 busy  output  1  high while a frame is partially captured.

Function
REQ-012 Patterns (g..a, active low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other value is invalid.
REQ-013 States: IDLE, CAPTURE; a strobe with no digit_en bit low SHALL be ignored in every state.
REQ-014 IDLE: strobe with digit_en selecting only position 0 and a valid pattern -> acc = digit, expected position = 1, go to CAPTURE (or complete at once if NDIG = 1).
REQ-015 IDLE: strobe on any other single position SHALL be ignored (wait for frame alignment), no error.
REQ-016 CAPTURE: strobe on the expected position with a valid pattern -> acc += digit * 10^position, expected position increments.
REQ-017 Frame completes when position NDIG-1 is captured: number <= final acc, number_valid pulses in the cycle after the completing strobe, state returns to IDLE.
REQ-018 CAPTURE abort conditions: invalid pattern, position other than expected, more than one digit_en bit low; each SHALL pulse frame_error the following cycle, discard acc, return to IDLE, leave number unchanged.
REQ-019 Exception: in CAPTURE, a valid strobe on position 0 restarts the frame (acc = digit, expected = 1) and SHALL also pulse frame_error.
REQ-020 IDLE: invalid pattern or multiple digit_en low on a strobe SHALL pulse frame_error, state stays IDLE.
REQ-021 number_valid and frame_error SHALL never be high in the same cycle.
REQ-022 Weights 10^k SHALL be constants; accumulation arithmetic is WIDTH bits wide, no overflow possible by REQ-002.
REQ-023 busy = (state == CAPTURE).
REQ-024 Strobes closer than one cycle apart (back-to-back) SHALL each be processed; no strobe is dropped.

Reset
REQ-025 n_reset low at a rising edge: state IDLE, acc 0, expected position 0, number 0, number_valid 0, frame_error 0.
REQ-026 Reset mid-frame SHALL discard the partial frame without a frame_error pulse.
REQ-027 A strobe in the reset cycle SHALL be ignored.

Structure
REQ-028 Package sevenseg_pkg SHALL hold the ten segment pattern constants, the state enum type and the power-of-ten weight constants.
REQ-029 Sub-module sevenseg_pattern_decode (combinational): seg -> 4-bit digit + valid flag, using only sevenseg_pkg patterns.
REQ-030 Remaining logic (FSM, accumulator, output registers) SHALL sit in sevenseg_frame_decoder; all outputs registered.

Verification
REQ-031 NDIG=2: strobe pos0 seg=0100100 (2), then pos1 seg=0011001 (4) -> number=42, number_valid one pulse one cycle after second strobe, frame_error 0.
REQ-032 NDIG=2: sweep all 0..99 frames -> number equals each driven value, exactly one valid pulse per frame.
REQ-033 pos0 valid, then pos1 seg=1111111 -> frame_error pulse, no number_valid, number keeps previous value, busy low after.
REQ-034 pos0 valid, then pos0 again (digit 7), then pos1 digit 3 -> frame_error once, then number=37.
REQ-035 digit_en=00 (both low) with strobe in CAPTURE -> frame_error, IDLE; strobe with digit_en=11 -> no change.
REQ-036 n_reset low after pos0 strobe -> busy 0, number 0, no pulses; subsequent full frame 58 -> number=58.
